// File: rtl/shiftreg_div_pkg.sv
// Shared definitions for the divided-clock phase monitor: divide-mode
// encodings, expected period/high-time lookup, FSM state type and the
// common counter width.
package shiftreg_div_pkg;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_DIV4    = 2'b00;
    localparam logic [1:0] MODE_DIV5    = 2'b11;
    localparam logic [1:0] MODE_DIV7    = 2'b01;
    localparam logic [1:0] MODE_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } period_spec_t;

    // Expected (period, high time) in clk cycles for each divide mode
    function automatic period_spec_t expected_spec(input logic [1:0] mode);
        period_spec_t s;
        s = '0;
        case (mode)
            MODE_DIV4: begin s.period = CNT_W'(4); s.high = CNT_W'(2); end
            MODE_DIV5: begin s.period = CNT_W'(5); s.high = CNT_W'(3); end
            MODE_DIV7: begin s.period = CNT_W'(7); s.high = CNT_W'(4); end
            default:   s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/shiftreg_phase_monitor_if.sv
// Signal bundle between the divider under test and the phase monitor.
// err_cnt is present only when PHMON_ERRCNT_EN is defined.
interface shiftreg_phase_monitor_if;
    import shiftreg_div_pkg::*;

    logic             phase0;
    logic             phase90;
    logic [1:0]       div_mode_sel;
    logic             locked;
    logic             err_period;
    logic             err_quad;
    logic             err_mode;
    logic [CNT_W-1:0] meas_period;
`ifdef PHMON_ERRCNT_EN
    logic [7:0]       err_cnt;

    modport master (
        output phase0, phase90, div_mode_sel,
        input  locked, err_period, err_quad, err_mode, meas_period, err_cnt
    );
    modport slave (
        input  phase0, phase90, div_mode_sel,
        output locked, err_period, err_quad, err_mode, meas_period, err_cnt
    );
`else
    modport master (
        output phase0, phase90, div_mode_sel,
        input  locked, err_period, err_quad, err_mode, meas_period
    );
    modport slave (
        input  phase0, phase90, div_mode_sel,
        output locked, err_period, err_quad, err_mode, meas_period
    );
`endif

endinterface

// File: rtl/shiftreg_period_meter.sv
// Edge detection and period / high-time measurement of phase0.
// All results are presented as registered events one clock after the
// corresponding condition is seen on the captured inputs.
module shiftreg_period_meter
    import shiftreg_div_pkg::*;
(
    input  logic             clk,
    input  logic             init_n,
    input  logic             phase0,
    input  logic             phase90,
    output logic             rise_evt,
    output logic             stuck_evt,
    output logic             quad_evt,
    output logic [CNT_W-1:0] period_snap,
    output logic [CNT_W-1:0] high_snap
);

    logic             p0_q;
    logic             p0_qq;
    logic             p90_q;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;

    assign rise = p0_q & ~p0_qq;

    // Capture stage for both phases plus the delayed phase0 for edge detect
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            p0_q  <= 1'b0;
            p0_qq <= 1'b0;
            p90_q <= 1'b0;
        end else begin
            p0_q  <= phase0;
            p0_qq <= p0_q;
            p90_q <= phase90;
        end
    end

    // Period and high-time counters, both restarting at 1 on a rising edge
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else begin
            if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_W'(1);
            if (p0_q && (high_cnt != CNT_MAX)) high_cnt <= high_cnt + CNT_W'(1);
        end
    end

    // Registered events; stuck fires only on the step into saturation
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rise_evt    <= 1'b0;
            stuck_evt   <= 1'b0;
            quad_evt    <= 1'b0;
            period_snap <= '0;
            high_snap   <= '0;
        end else begin
            rise_evt  <= rise;
            stuck_evt <= ~rise & (period_cnt == (CNT_MAX - CNT_W'(1)));
            quad_evt  <= p90_q ^ p0_qq;
            if (rise) begin
                period_snap <= period_cnt;
                high_snap   <= high_cnt;
            end
        end
    end

endmodule

// File: rtl/shiftreg_phase_monitor.sv
// Lock monitor for a shift-register clock divider: checks the period and
// high time of phase0 against the selected divide mode and the quadrature
// relation of phase90. Define PHMON_ERRCNT_EN to add the err_cnt output.
module shiftreg_phase_monitor
    import shiftreg_div_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4
) (
    input logic                     clk,
    input logic                     init_n,
    shiftreg_phase_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_CNT);

    logic             rise_evt;
    logic             stuck_evt;
    logic             quad_evt;
    logic [CNT_W-1:0] period_snap;
    logic [CNT_W-1:0] high_snap;

    logic [1:0]       mode_q;
    logic [1:0]       mode_qq;
    logic [1:0]       mode_cur;
    logic             mode_chg;

    state_t           state;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] good_inc;
    logic             period_good;
    logic             period_bad;
    period_spec_t     spec;

    logic             locked_q;
    logic             err_period_q;
    logic             err_quad_q;
    logic             err_mode_q;
    logic [CNT_W-1:0] meas_period_q;

    shiftreg_period_meter u_meter (
        .clk         (clk),
        .init_n      (init_n),
        .phase0      (mon.phase0),
        .phase90     (mon.phase90),
        .rise_evt    (rise_evt),
        .stuck_evt   (stuck_evt),
        .quad_evt    (quad_evt),
        .period_snap (period_snap),
        .high_snap   (high_snap)
    );

    // Two-stage mode pipeline keeps mode changes aligned with the meter events
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            mode_q  <= MODE_DIV4;
            mode_qq <= MODE_DIV4;
        end else begin
            mode_q  <= mon.div_mode_sel;
            mode_qq <= mode_q;
        end
    end

    assign mode_chg    = (mode_qq != mode_cur);
    assign spec        = expected_spec(mode_cur);
    assign period_good = (period_snap == spec.period) && (high_snap == spec.high);
    assign period_bad  = rise_evt & ~period_good;
    assign good_inc    = good_cnt + CNT_W'(1);

    // Lock FSM with registered status and error outputs
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state         <= ST_IDLE;
            good_cnt      <= '0;
            mode_cur      <= MODE_DIV4;
            locked_q      <= 1'b0;
            err_period_q  <= 1'b0;
            err_quad_q    <= 1'b0;
            err_mode_q    <= 1'b0;
            meas_period_q <= '0;
        end else begin
            err_period_q <= 1'b0;
            err_quad_q   <= 1'b0;
            if (mode_chg) begin
                mode_cur   <= mode_qq;
                state      <= ST_IDLE;
                good_cnt   <= '0;
                locked_q   <= 1'b0;
                err_mode_q <= (mode_qq == MODE_ILLEGAL);
            end else if (mode_cur == MODE_ILLEGAL) begin
                state      <= ST_IDLE;
                good_cnt   <= '0;
                locked_q   <= 1'b0;
                err_mode_q <= 1'b1;
            end else begin
                err_mode_q <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        good_cnt <= '0;
                        locked_q <= 1'b0;
                        if (rise_evt) state <= ST_ACQUIRE;
                    end
                    default: begin
                        if (rise_evt) meas_period_q <= period_snap;
                        err_quad_q   <= quad_evt;
                        err_period_q <= stuck_evt | period_bad;
                        if (stuck_evt) begin
                            state    <= ST_IDLE;
                            good_cnt <= '0;
                            locked_q <= 1'b0;
                        end else if (quad_evt | period_bad) begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                            locked_q <= 1'b0;
                        end else if (rise_evt && (state == ST_ACQUIRE)) begin
                            good_cnt <= good_inc;
                            if (good_inc == LOCK_TARGET) begin
                                state    <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign mon.locked      = locked_q;
    assign mon.err_period  = err_period_q;
    assign mon.err_quad    = err_quad_q;
    assign mon.err_mode    = err_mode_q;
    assign mon.meas_period = meas_period_q;

`ifdef PHMON_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [8:0] err_sum;

    // Counts pulses as they leave the outputs, so it trails them by one clock
    assign err_sum = {1'b0, err_cnt_q} + {8'd0, err_period_q} + {8'd0, err_quad_q};

    // Saturating error counter, cleared on mode change
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            err_cnt_q <= '0;
        end else if (mode_chg) begin
            err_cnt_q <= '0;
        end else if (err_sum[8]) begin
            err_cnt_q <= '1;
        end else begin
            err_cnt_q <= err_sum[7:0];
        end
    end

    assign mon.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_shiftreg_phase_monitor.sv
// Directed bench for shiftreg_phase_monitor: a table of generator settings
// with hand-computed results, plus sequences for lock loss, stuck input,
// mode changes and asynchronous reset. Covers err_cnt when
// PHMON_ERRCNT_EN is defined.
module tb_shiftreg_phase_monitor;

    logic clk = 1'b0;
    logic init_n;
    logic last_p0;

    int n_vec = 0;
    int n_bad = 0;
    int n_ep  = 0;
    int n_eq  = 0;
    int ep0;
    int eq0;

    always #5 clk = ~clk;

    shiftreg_phase_monitor_if mon ();

    shiftreg_phase_monitor #(.LOCK_CNT(4)) dut (
        .clk    (clk),
        .init_n (init_n),
        .mon    (mon)
    );

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (mon.err_period === 1'b1) n_ep++;
        if (mon.err_quad === 1'b1) n_eq++;
    end

    typedef struct {
        logic [1:0] mode;
        int         high;
        int         low;
        int         nper;
        int         exp_locked;
        int         exp_meas;
        int         exp_ep;
        int         exp_eq;
        int         exp_err_mode;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic p0, input logic force_eq);
        mon.phase0  = p0;
        mon.phase90 = force_eq ? p0 : last_p0;
        last_p0     = p0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0);
    endtask

    task automatic run_periods(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < h; i++) drive(1'b1, 1'b0);
            for (int i = 0; i < l; i++) drive(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input logic [1:0] mode);
        mon.div_mode_sel = mode;
        mon.phase0       = 1'b0;
        mon.phase90      = 1'b0;
        last_p0          = 1'b0;
        init_n           = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        init_n = 1'b1;
        idle(6);
    endtask

    task automatic snap();
        ep0 = n_ep;
        eq0 = n_eq;
    endtask

    initial begin
        //          mode   H  L  N  lock meas ep eq emode
        tbl[0] = '{2'b01, 4, 3, 5, 1, 7, 0, 0, 0};
        tbl[1] = '{2'b01, 4, 3, 4, 0, 7, 0, 0, 0};
        tbl[2] = '{2'b00, 2, 2, 5, 1, 4, 0, 0, 0};
        tbl[3] = '{2'b11, 3, 2, 5, 1, 5, 0, 0, 0};
        tbl[4] = '{2'b00, 3, 2, 6, 0, 5, 5, 0, 0};
        tbl[5] = '{2'b11, 2, 3, 4, 0, 5, 3, 0, 0};
        tbl[6] = '{2'b10, 2, 2, 6, 0, 0, 0, 0, 1};
        tbl[7] = '{2'b01, 3, 4, 5, 0, 7, 4, 0, 0};

        // Outputs while reset is held
        init_n           = 1'b0;
        mon.phase0       = 1'b0;
        mon.phase90      = 1'b0;
        mon.div_mode_sel = 2'b00;
        last_p0          = 1'b0;
        #1;
        check("reset locked", 32'(mon.locked), 0);
        check("reset err_period", 32'(mon.err_period), 0);
        check("reset err_quad", 32'(mon.err_quad), 0);
        check("reset err_mode", 32'(mon.err_mode), 0);
        check("reset meas_period", 32'(mon.meas_period), 0);

        // Table: generator settings against final status and pulse counts
        for (int v = 0; v < 8; v++) begin
            do_reset(tbl[v].mode);
            snap();
            run_periods(tbl[v].high, tbl[v].low, tbl[v].nper);
            check($sformatf("v%0d locked", v), 32'(mon.locked), 32'(tbl[v].exp_locked));
            check($sformatf("v%0d meas", v), 32'(mon.meas_period), 32'(tbl[v].exp_meas));
            check($sformatf("v%0d err_period pulses", v), 32'(n_ep - ep0), 32'(tbl[v].exp_ep));
            check($sformatf("v%0d err_quad pulses", v), 32'(n_eq - eq0), 32'(tbl[v].exp_eq));
            check($sformatf("v%0d err_mode", v), 32'(mon.err_mode), 32'(tbl[v].exp_err_mode));
        end

        // Illegal mode latency and recovery into /7
        do_reset(2'b01);
        snap();
        mon.div_mode_sel = 2'b10;
        @(posedge clk); #1;
        check("illegal edge1 err_mode", 32'(mon.err_mode), 0);
        @(posedge clk); #1;
        check("illegal edge2 err_mode", 32'(mon.err_mode), 0);
        @(posedge clk); #1;
        check("illegal edge3 err_mode", 32'(mon.err_mode), 1);
        run_periods(2, 2, 3);
        check("illegal locked", 32'(mon.locked), 0);
        mon.div_mode_sel = 2'b01;
        idle(3);
        check("legal again err_mode", 32'(mon.err_mode), 0);
        run_periods(4, 3, 4);
        check("relock after 4 rises", 32'(mon.locked), 0);
        run_periods(4, 3, 1);
        check("relock after 5 rises", 32'(mon.locked), 1);
        check("mode seq err_period pulses", 32'(n_ep - ep0), 0);
        check("mode seq err_quad pulses", 32'(n_eq - eq0), 0);

        // /4 lock, one stretched period, relock
        do_reset(2'b00);
        run_periods(2, 2, 5);
        check("div4 locked", 32'(mon.locked), 1);
        snap();
        run_periods(2, 3, 1);
        run_periods(2, 2, 1);
        check("stretch meas", 32'(mon.meas_period), 5);
        check("stretch locked", 32'(mon.locked), 0);
        check("stretch err_period pulses", 32'(n_ep - ep0), 1);
        run_periods(2, 2, 3);
        check("stretch 3 good locked", 32'(mon.locked), 0);
        check("stretch meas back", 32'(mon.meas_period), 4);
        run_periods(2, 2, 1);
        check("stretch relocked", 32'(mon.locked), 1);
        check("stretch total err_period", 32'(n_ep - ep0), 1);
        check("stretch err_quad", 32'(n_eq - eq0), 0);

        // /5 lock, phase90 equal to phase0 for one cycle on a rising edge
        do_reset(2'b11);
        run_periods(3, 2, 5);
        check("div5 locked", 32'(mon.locked), 1);
        snap();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("quad err_quad pulses", 32'(n_eq - eq0), 1);
        check("quad err_period pulses", 32'(n_ep - ep0), 0);
        check("quad locked", 32'(mon.locked), 0);
        run_periods(3, 2, 3);
        check("quad 3 good locked", 32'(mon.locked), 0);
        run_periods(3, 2, 1);
        check("quad relocked", 32'(mon.locked), 1);

        // Stuck phase0 from lock: one pulse, back to IDLE
        do_reset(2'b01);
        run_periods(4, 3, 5);
        check("stuck pre locked", 32'(mon.locked), 1);
        snap();
        idle(20);
        check("stuck err_period pulses", 32'(n_ep - ep0), 1);
        check("stuck err_quad pulses", 32'(n_eq - eq0), 0);
        check("stuck locked", 32'(mon.locked), 0);
        run_periods(4, 3, 4);
        check("stuck 4 rises locked", 32'(mon.locked), 0);
        run_periods(4, 3, 1);
        check("stuck 5 rises locked", 32'(mon.locked), 1);
        check("stuck total err_period", 32'(n_ep - ep0), 1);

        // Mode change while locked: silent return to IDLE
        do_reset(2'b00);
        run_periods(2, 2, 5);
        check("chg pre locked", 32'(mon.locked), 1);
        snap();
        mon.div_mode_sel = 2'b11;
        idle(3);
        check("chg locked", 32'(mon.locked), 0);
        run_periods(3, 2, 4);
        check("chg 4 rises locked", 32'(mon.locked), 0);
        run_periods(3, 2, 1);
        check("chg 5 rises locked", 32'(mon.locked), 1);
        check("chg err_period pulses", 32'(n_ep - ep0), 0);
        check("chg err_quad pulses", 32'(n_eq - eq0), 0);

        // Asynchronous reset mid-lock
        do_reset(2'b01);
        run_periods(4, 3, 5);
        check("areset pre locked", 32'(mon.locked), 1);
        check("areset pre meas", 32'(mon.meas_period), 7);
        #2;
        init_n = 1'b0;
        #1;
        check("areset locked", 32'(mon.locked), 0);
        check("areset meas", 32'(mon.meas_period), 0);
        check("areset err_mode", 32'(mon.err_mode), 0);
        check("areset err_period", 32'(mon.err_period), 0);
        check("areset err_quad", 32'(mon.err_quad), 0);
        @(posedge clk);
        #1;
        init_n = 1'b1;
        idle(6);
        run_periods(4, 3, 4);
        check("areset 4 rises locked", 32'(mon.locked), 0);
        run_periods(4, 3, 1);
        check("areset 5 rises locked", 32'(mon.locked), 1);

`ifdef PHMON_ERRCNT_EN
        // Error counter: cleared by reset, saturates under continuous errors
        do_reset(2'b00);
        check("err_cnt after reset", 32'(mon.err_cnt), 0);
        run_periods(2, 2, 2);
        for (int i = 0; i < 300; i++) begin
            mon.phase0  = ((i % 4) < 2);
            mon.phase90 = ~last_p0;
            last_p0     = mon.phase0;
            @(posedge clk);
            #1;
        end
        check("err_cnt saturated", 32'(mon.err_cnt), 255);
        init_n = 1'b0;
        #1;
        check("err_cnt async clear", 32'(mon.err_cnt), 0);
        init_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
